dfe_cfg_sequencer: RTL and testbench
====================================

Name: dfe_cfg_sequencer

Overview:
Configuration sequencer that turns host "load jobs" into APB master-side write transactions for the DFE filter array's APB bridge.
- Each job streams N coefficient words into one register-bank component (fractional decimator, IIR, CTRL, CIC_R) at consecutive addresses.
- A job can optionally finish with a CTRL-bank enable write that sets the decimator clk_enable bit.
- The block sits between the host/config source and the bridge's MTRANS/MWRITE/MSELx/MADDR/MWDATA inputs, and uses the bridge's PREADY as the access-complete handshake.

Parameters:
- ADDR_WIDTH, 7, APB address width (MADDR)
- DATA_WIDTH, 20, write-data width (MWDATA, coefficient width)
- COMP, 4, number of PSEL targets (MSELx width)
- LEN_WIDTH, 7, width of the job word count
- CTRL_ADDR, 0, CTRL-bank address of the enable word
- CTRL_EN_WORD, 1, data written by the enable write (bit0 = clk_enable)
- TIMEOUT, 255, maximum cycles to wait for m_ready per access

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  job request valid
- cmd_ready  out  1  job accepted when cmd_valid && cmd_ready
- cmd_comp  in  2  target component index (0 FRAC_DECI, 1 IIR, 2 CTRL, 3 CIC_R)
- cmd_base  in  ADDR_WIDTH  first write address
- cmd_len  in  LEN_WIDTH  number of data words (0 legal)
- cmd_en_after  in  1  issue CTRL enable write after the data words
- wr_valid  in  1  data word valid
- wr_ready  out  1  data word consumed when wr_valid && wr_ready
- wr_data  in  DATA_WIDTH  coefficient word
- abort  in  1  abandon the current job
- m_ready  in  1  bridge PREADY; access complete
- MTRANS  out  1  transfer request to the bridge
- MWRITE  out  1  write strobe, always 1 when MTRANS = 1
- MSELx  out  COMP  one-hot target select
- MADDR  out  ADDR_WIDTH  write address
- MWDATA  out  DATA_WIDTH  write data
- busy  out  1  job in progress
- done  out  1  one-cycle pulse on successful job completion
- err  out  1  one-cycle pulse on rejected, timed-out or aborted job

Behaviour:
- Reset (rst = 1 at a clk edge): state IDLE. All outputs are 0 except cmd_ready = 1. Index and timeout counters are cleared. A reset mid-access drops MTRANS on the next cycle with no completion.
- States: IDLE, FETCH, ACCESS, CTRL_ACCESS, FINISH.
- IDLE:
  - cmd_ready = 1.
  - On handshake, latch comp/base/len/en_after and set idx = 0.
  - Reject (err pulse next cycle, stay IDLE, no bus activity) if base + len > 2^ADDR_WIDTH, or if len = 0 && !en_after.
  - Otherwise set busy = 1 and go to FETCH if len > 0, else to CTRL_ACCESS.
- FETCH:
  - wr_ready = 1.
  - On wr_valid, latch wr_data into MWDATA, set MADDR = base + idx and MSELx = 1 << comp, and go to ACCESS.
  - wr_ready is 0 in every other state.
- ACCESS:
  - MTRANS = MWRITE = 1; MSELx, MADDR and MWDATA are held stable.
  - On m_ready = 1 at a clk edge: deassert MTRANS the following cycle and increment idx.
  - Then: if idx == len-1, go to CTRL_ACCESS when en_after, else FINISH; otherwise go to FETCH.
  - Minimum 2 cycles per word (FETCH + ACCESS), no back-to-back MTRANS.
- CTRL_ACCESS: MTRANS = MWRITE = 1, MSELx = 4'b0100, MADDR = CTRL_ADDR, MWDATA = CTRL_EN_WORD. On m_ready, go to FINISH.
- FINISH: done = 1 for one cycle, busy = 0, return to IDLE.
- Timeout:
  - The counter runs while MTRANS = 1 and clears on entry to each access.
  - Reaching TIMEOUT without m_ready: drop MTRANS, pulse err, return to IDLE. No done pulse.
- Abort:
  - In FETCH (or when a job starts), return to IDLE next cycle and pulse err. No more words are consumed.
  - In ACCESS/CTRL_ACCESS, complete the current access (wait for m_ready or timeout), then return to IDLE and pulse err. The CTRL enable write is skipped.
  - Abort in IDLE is ignored.
- Simultaneous events:
  - m_ready and timeout in the same cycle: m_ready wins.
  - abort and m_ready in the same cycle: the access completes, then abort is honoured.
- m_ready outside an access is ignored.
- Arithmetic: the address sum is computed at ADDR_WIDTH+1 bits for the range check; MADDR is the truncated sum. idx is LEN_WIDTH bits.

Decomposition:
- Package dfe_cfg_pkg holds:
  - state enum (cfg_state_e)
  - component index constants COMP_FRAC_DECI = 0, COMP_IIR = 1, COMP_CTRL = 2, COMP_CIC_R = 3
  - default CTRL_ADDR and CTRL_EN_WORD
- Sub-module dfe_cfg_timeout: a load/clear/expire down-counter instantiated once. Everything else stays in the top FSM.

Test Plan:
- Job comp = 0, base = 0, len = 3, en_after = 0, data 0x00011/0x00022/0x00033 with m_ready returned 1 cycle after MTRANS -> three writes, MSELx = 0001, MADDR 0, 1, 2, MWDATA matches, done pulses once, busy is low afterwards.
- Job comp = 1, base = 10, len = 2, en_after = 1 -> writes to addresses 10 and 11 with MSELx = 0010, then MSELx = 0100, MADDR = 0, MWDATA = 1, then done.
- Job base = 120, len = 10 (130 > 128) -> err pulse, MTRANS never asserted, wr_ready stays 0.
- Job len = 2 with m_ready held 0 -> MTRANS high for exactly 255 cycles, then err, IDLE, one word consumed.
- Abort asserted mid-ACCESS of word 1 of 4, m_ready 3 cycles later -> access completes, then err, no further wr_ready, no CTRL write.
- wr_valid stalled 5 cycles in FETCH, and rst asserted during an ACCESS -> no MTRANS while waiting; after reset all outputs are 0 and cmd_ready = 1 next cycle.

Source files
------------

// File: rtl/dfe_cfg_pkg.sv
// -----------------------------------------------------------------------------
// dfe_cfg_pkg
// Shared types and defaults for the DFE configuration sequencer.
//   cfg_state_e : sequencer FSM states
//   comp_e      : register-bank component index (MSELx bit position)
//   DEF_*       : default CTRL-bank enable write (address / data)
// -----------------------------------------------------------------------------
package dfe_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ACCESS,
        CTRL_ACCESS,
        FINISH
    } cfg_state_e;

    typedef enum logic [1:0] {
        COMP_FRAC_DECI = 2'd0,
        COMP_IIR       = 2'd1,
        COMP_CTRL      = 2'd2,
        COMP_CIC_R     = 2'd3
    } comp_e;

    localparam int unsigned DEF_CTRL_ADDR    = 0;
    // bit0 = decimator clk_enable
    localparam int unsigned DEF_CTRL_EN_WORD = 1;

endpackage

// File: rtl/dfe_cfg_sequencer_if.sv
// -----------------------------------------------------------------------------
// dfe_cfg_sequencer_if
// APB master-side request bus between the sequencer and the filter-array
// bridge.
//   MTRANS/MWRITE : transfer request / write strobe (master -> bridge)
//   MSELx         : one-hot component select        (master -> bridge)
//   MADDR/MWDATA  : write address / data            (master -> bridge)
//   m_ready       : bridge PREADY, access complete  (bridge -> master)
// -----------------------------------------------------------------------------
interface dfe_cfg_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned COMP       = 4
);
    logic                  MTRANS;
    logic                  MWRITE;
    logic [COMP-1:0]       MSELx;
    logic [ADDR_WIDTH-1:0] MADDR;
    logic [DATA_WIDTH-1:0] MWDATA;
    logic                  m_ready;

    modport master (output MTRANS, MWRITE, MSELx, MADDR, MWDATA, input m_ready);
    modport slave  (input MTRANS, MWRITE, MSELx, MADDR, MWDATA, output m_ready);
endinterface

// File: rtl/dfe_cfg_timeout.sv
// -----------------------------------------------------------------------------
// dfe_cfg_timeout
// Per-access watchdog: loaded when an access starts, counts down while the
// access is outstanding, flags expiry on the TIMEOUT-th outstanding cycle.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force the counter to zero
//   load     : arm for a new access (takes effect on the first MTRANS cycle)
//   en       : access outstanding (MTRANS high)
//   expired  : TIMEOUT outstanding cycles reached in this cycle
// -----------------------------------------------------------------------------
module dfe_cfg_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Loading TIMEOUT-1 makes the count reach zero on the TIMEOUT-th
    // outstanding cycle, so expiry acts at the end of exactly that cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_W'(TIMEOUT - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/dfe_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// dfe_cfg_sequencer
// Turns host load jobs into APB-bridge write transfers: N coefficient words
// to consecutive addresses of one component, optionally followed by the
// CTRL-bank clk_enable write.
//   clk, rst        : clock, synchronous active-high reset
//   cmd_*           : job request (valid/ready, comp, base, len, en_after)
//   wr_*            : coefficient word stream (valid/ready, data)
//   abort           : abandon the current job
//   bus (master)    : MTRANS/MWRITE/MSELx/MADDR/MWDATA out, m_ready in
//   busy/done/err   : job in progress / success pulse / failure pulse
// -----------------------------------------------------------------------------
module dfe_cfg_sequencer
    import dfe_cfg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 7,
    parameter int unsigned DATA_WIDTH   = 20,
    parameter int unsigned COMP         = 4,
    parameter int unsigned LEN_WIDTH    = 7,
    parameter int unsigned CTRL_ADDR    = DEF_CTRL_ADDR,
    parameter int unsigned CTRL_EN_WORD = DEF_CTRL_EN_WORD,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_comp,
    input  logic [ADDR_WIDTH-1:0]  cmd_base,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    input  logic                   cmd_en_after,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   abort,
    dfe_cfg_sequencer_if.master    bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    // Range check needs one bit beyond the wider operand so base+len never wraps.
    localparam int unsigned SUM_W = ((LEN_WIDTH > ADDR_WIDTH) ? LEN_WIDTH : ADDR_WIDTH) + 1;
    localparam logic [SUM_W-1:0] RANGE_LIMIT = SUM_W'(1) << ADDR_WIDTH;

    cfg_state_e            state_q, state_d;
    comp_e                 comp_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q, idx_q;
    logic                  en_after_q, abort_pend_q, ctrl_go_q, err_q;
    logic [COMP-1:0]       msel_q;
    logic [ADDR_WIDTH-1:0] maddr_q;
    logic [DATA_WIDTH-1:0] mwdata_q;

    logic [SUM_W-1:0] range_end;
    logic cmd_reject, mtrans, last_word, abort_seen, tmo_expired;
    logic latch_cmd, load_word, load_ctrl, idx_inc, end_access, tmo_load, err_set;

    assign range_end  = SUM_W'(cmd_base) + SUM_W'(cmd_len);
    assign cmd_reject = (range_end > RANGE_LIMIT) || ((cmd_len == '0) && !cmd_en_after);
    // CTRL_ACCESS spends one cycle (ctrl_go_q low) setting up the enable word,
    // which keeps MTRANS low between the last data word and the CTRL write.
    assign mtrans     = (state_q == ACCESS) || ((state_q == CTRL_ACCESS) && ctrl_go_q);
    assign last_word  = (idx_q == (len_q - LEN_WIDTH'(1)));
    assign abort_seen = abort_pend_q || abort;

    dfe_cfg_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == IDLE),
        .load    (tmo_load),
        .en      (mtrans),
        .expired (tmo_expired)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        latch_cmd  = 1'b0;
        load_word  = 1'b0;
        load_ctrl  = 1'b0;
        idx_inc    = 1'b0;
        end_access = 1'b0;
        tmo_load   = 1'b0;
        err_set    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    latch_cmd = 1'b1;
                    if (cmd_reject || abort) err_set = 1'b1;
                    else if (cmd_len != '0)  state_d = FETCH;
                    else                     state_d = CTRL_ACCESS;
                end
            end
            FETCH: begin
                if (abort) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else if (wr_valid) begin
                    load_word = 1'b1;
                    tmo_load  = 1'b1;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                // m_ready outranks both timeout and a pending abort.
                if (bus.m_ready) begin
                    idx_inc    = 1'b1;
                    end_access = 1'b1;
                    if (abort_seen) begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end else if (last_word) begin
                        state_d = en_after_q ? CTRL_ACCESS : FINISH;
                    end else begin
                        state_d = FETCH;
                    end
                end else if (tmo_expired) begin
                    end_access = 1'b1;
                    err_set    = 1'b1;
                    state_d    = IDLE;
                end
            end
            CTRL_ACCESS: begin
                if (!ctrl_go_q) begin
                    if (abort) begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end else begin
                        load_ctrl = 1'b1;
                        tmo_load  = 1'b1;
                    end
                end else if (bus.m_ready) begin
                    end_access = 1'b1;
                    if (abort_seen) begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = FINISH;
                    end
                end else if (tmo_expired) begin
                    end_access = 1'b1;
                    err_set    = 1'b1;
                    state_d    = IDLE;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            comp_q       <= COMP_FRAC_DECI;
            base_q       <= '0;
            len_q        <= '0;
            en_after_q   <= 1'b0;
            idx_q        <= '0;
            abort_pend_q <= 1'b0;
            ctrl_go_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= err_set;
            if (latch_cmd) begin
                comp_q     <= comp_e'(cmd_comp);
                base_q     <= cmd_base;
                len_q      <= cmd_len;
                en_after_q <= cmd_en_after;
                idx_q      <= '0;
            end else if (idx_inc) begin
                idx_q <= idx_q + LEN_WIDTH'(1);
            end
            // Abort during an outstanding access is remembered until it completes.
            if (state_d == IDLE)    abort_pend_q <= 1'b0;
            else if (abort && mtrans) abort_pend_q <= 1'b1;
            if (state_d != CTRL_ACCESS) ctrl_go_q <= 1'b0;
            else if (load_ctrl)         ctrl_go_q <= 1'b1;
        end
    end

    // NOTE: the bus datapath registers are reset too, so every bus output reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            msel_q   <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else if (load_word) begin
            msel_q   <= COMP'(1) << comp_q;
            maddr_q  <= base_q + ADDR_WIDTH'(idx_q);
            mwdata_q <= wr_data;
        end else if (load_ctrl) begin
            msel_q   <= COMP'(1) << COMP_CTRL;
            maddr_q  <= ADDR_WIDTH'(CTRL_ADDR);
            mwdata_q <= DATA_WIDTH'(CTRL_EN_WORD);
        end else if (end_access) begin
            msel_q   <= '0;
        end
    end

    assign bus.MTRANS = mtrans;
    assign bus.MWRITE = mtrans;
    assign bus.MSELx  = msel_q;
    assign bus.MADDR  = maddr_q;
    assign bus.MWDATA = mwdata_q;

    assign cmd_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == FETCH) && !abort;
    assign busy      = (state_q == FETCH) || (state_q == ACCESS) || (state_q == CTRL_ACCESS);
    assign done      = (state_q == FINISH);
    assign err       = err_q;

endmodule

// File: tb/tb_dfe_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dfe_cfg_sequencer
// Directed bench for dfe_cfg_sequencer. Inputs change on the falling edge;
// outputs are sampled 4 ns later, just before the rising edge. Expected bus
// writes are queued when a job is issued and compared as each transfer starts.
// -----------------------------------------------------------------------------
module tb_dfe_cfg_sequencer;

    typedef struct packed {
        logic [3:0]  sel;
        logic [6:0]  addr;
        logic [19:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_en_after;
    logic [1:0]  cmd_comp;
    logic [6:0]  cmd_base, cmd_len;
    logic        wr_valid, wr_ready;
    logic [19:0] wr_data;
    logic        abort, busy, done, err;

    dfe_cfg_sequencer_if #(.ADDR_WIDTH(7), .DATA_WIDTH(20), .COMP(4)) bus ();

    dfe_cfg_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_comp     (cmd_comp),
        .cmd_base     (cmd_base),
        .cmd_len      (cmd_len),
        .cmd_en_after (cmd_en_after),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .abort        (abort),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    txn_t        exp_q[$];
    logic [19:0] wr_q[$];
    int rdy_lat   = 1;   // m_ready rises in MTRANS cycle rdy_lat+1; -1 = never
    int stall_cnt = 0;
    int done_cnt = 0, err_cnt = 0, txn_cnt = 0, mtrans_cyc = 0, words_cnt = 0, wr_ready_cyc = 0;
    int s_done, s_err, s_txn, s_mtrans, s_words, s_wrr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [3:0] s, input logic [6:0] a, input logic [19:0] d);
        txn_t t;
        t.sel = s; t.addr = a; t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic snap();
        s_done = done_cnt; s_err = err_cnt; s_txn = txn_cnt;
        s_mtrans = mtrans_cyc; s_words = words_cnt; s_wrr = wr_ready_cyc;
    endtask

    task automatic send_cmd(input logic [1:0] c, input logic [6:0] b, input logic [6:0] l, input logic e);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_comp = c; cmd_base = b; cmd_len = l; cmd_en_after = e;
        #4 check("cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while ((done_cnt + err_cnt == s_done + s_err) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check("job_end_within_budget", n < budget, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_mtrans(input int budget);
        int n = 0;
        while (!bus.MTRANS && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check("mtrans_seen_within_budget", bus.MTRANS, 1);
    endtask

    task automatic check_job(input string tag, input int d, input int e, input int t, input int w);
        check({tag, "_done"},  done_cnt - s_done, d);
        check({tag, "_err"},   err_cnt - s_err, e);
        check({tag, "_txns"},  txn_cnt - s_txn, t);
        check({tag, "_words"}, words_cnt - s_words, w);
        check({tag, "_idle"},  {busy, cmd_ready}, 2'b01);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    // Bridge responder, word source and bus monitor.
    initial begin : monitor
        int   k;
        logic prev_cmpl;
        txn_t cur, e;
        k = 0; prev_cmpl = 1'b0;
        bus.m_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
        forever begin
            @(negedge clk);
            if (bus.MTRANS) k++; else k = 0;
            bus.m_ready = bus.MTRANS && (rdy_lat >= 0) && (k == rdy_lat + 1);
            if (stall_cnt > 0) begin
                stall_cnt--;
                wr_valid = 1'b0;
            end else begin
                wr_valid = (wr_q.size() != 0);
            end
            wr_data = (wr_q.size() != 0) ? wr_q[0] : 20'h0;
            #4;
            if (wr_valid && wr_ready) begin
                void'(wr_q.pop_front());
                words_cnt++;
            end
            if (wr_ready) wr_ready_cyc++;
            if (done) done_cnt++;
            if (err)  err_cnt++;
            if (bus.MTRANS) begin
                mtrans_cyc++;
                if (k == 1) begin
                    txn_cnt++;
                    cur.sel = bus.MSELx; cur.addr = bus.MADDR; cur.data = bus.MWDATA;
                    check("no_back_to_back", prev_cmpl, 0);
                    check("mwrite", bus.MWRITE, 1);
                    check("txn_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("txn_sel",  cur.sel,  e.sel);
                        check("txn_addr", cur.addr, e.addr);
                        check("txn_data", cur.data, e.data);
                    end
                end
                if (bus.m_ready) check("txn_held", {bus.MSELx, bus.MADDR, bus.MWDATA}, cur);
            end
            prev_cmpl = bus.MTRANS && bus.m_ready;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [19:0] d;
        int wrr_at_abort;
        rst = 1'b1; cmd_valid = 1'b0; cmd_comp = '0; cmd_base = '0; cmd_len = '0;
        cmd_en_after = 1'b0; abort = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #4;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_ctl", {wr_ready, busy, done, err, bus.MTRANS, bus.MWRITE}, 6'b0);
        check("rst_bus", {bus.MSELx, bus.MADDR, bus.MWDATA}, 31'h0);
        @(negedge clk);
        rst = 1'b0;

        // Three words to FRAC_DECI at 0..2, no enable write
        snap(); rdy_lat = 1;
        for (int i = 0; i < 3; i++) begin
            d = 20'h00011 * 20'(i + 1);
            wr_q.push_back(d);
            expect_wr(4'b0001, 7'(i), d);
        end
        send_cmd(2'd0, 7'd0, 7'd3, 1'b0);
        #4 check("t1_busy", busy, 1);
        wait_end(100);
        check_job("t1", 1, 0, 3, 3);
        check("t1_mtrans_cycles", mtrans_cyc - s_mtrans, 6);

        // Two words to IIR at 10/11, then CTRL enable write
        snap();
        wr_q.push_back(20'hABCDE); expect_wr(4'b0010, 7'd10, 20'hABCDE);
        wr_q.push_back(20'h12345); expect_wr(4'b0010, 7'd11, 20'h12345);
        expect_wr(4'b0100, 7'd0, 20'h00001);
        send_cmd(2'd1, 7'd10, 7'd2, 1'b1);
        wait_end(100);
        check_job("t2", 1, 0, 3, 2);

        // Range overflow 120+10 > 128: rejected with no bus activity
        snap();
        send_cmd(2'd0, 7'd120, 7'd10, 1'b0);
        wait_end(20);
        check_job("t3_range", 0, 1, 0, 0);
        check("t3_no_wr_ready", wr_ready_cyc - s_wrr, 0);

        // Zero length without enable write: rejected
        snap();
        send_cmd(2'd2, 7'd5, 7'd0, 1'b0);
        wait_end(20);
        check_job("t3_len0", 0, 1, 0, 0);

        // Exact fit 120+8 = 128 to CIC_R: accepted
        snap();
        for (int i = 0; i < 8; i++) begin
            d = 20'hC0000 + 20'(i);
            wr_q.push_back(d);
            expect_wr(4'b1000, 7'(120 + i), d);
        end
        send_cmd(2'd3, 7'd120, 7'd8, 1'b0);
        wait_end(200);
        check_job("t3_fit", 1, 0, 8, 8);

        // Zero length with enable write: CTRL write only
        snap();
        expect_wr(4'b0100, 7'd0, 20'h00001);
        send_cmd(2'd1, 7'd50, 7'd0, 1'b1);
        wait_end(50);
        check_job("t3_ctrl_only", 1, 0, 1, 0);

        // Timeout: m_ready never returns
        snap(); rdy_lat = -1;
        wr_q.push_back(20'h0F0F0); expect_wr(4'b0001, 7'd5, 20'h0F0F0);
        wr_q.push_back(20'h0E0E0);
        send_cmd(2'd0, 7'd5, 7'd2, 1'b0);
        wait_end(400);
        wr_q.delete();
        check_job("t4_timeout", 0, 1, 1, 1);
        check("t4_mtrans_cycles", mtrans_cyc - s_mtrans, 255);

        // Abort during the first access of four, m_ready 3 cycles later
        snap(); rdy_lat = 4;
        for (int i = 0; i < 4; i++) wr_q.push_back(20'h70000 + 20'(i));
        expect_wr(4'b0010, 7'd20, 20'h70000);
        send_cmd(2'd1, 7'd20, 7'd4, 1'b1);
        wait_mtrans(20);
        @(negedge clk);
        abort = 1'b1;
        wrr_at_abort = wr_ready_cyc;
        @(negedge clk);
        abort = 1'b0;
        wait_end(100);
        wr_q.delete();
        check_job("t5_abort", 0, 1, 1, 1);
        check("t5_no_wr_ready_after_abort", wr_ready_cyc - wrr_at_abort, 0);
        check("t5_mtrans_cycles", mtrans_cyc - s_mtrans, 5);

        // wr_valid stalled in FETCH: no transfer while waiting
        snap(); rdy_lat = 1; stall_cnt = 7;
        wr_q.push_back(20'h5A5A5); expect_wr(4'b1000, 7'd40, 20'h5A5A5);
        send_cmd(2'd3, 7'd40, 7'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #4 check("t6_stall_fetch", {bus.MTRANS, wr_ready, busy}, 3'b011);
            @(negedge clk);
        end
        wait_end(50);
        check_job("t6_stall", 1, 0, 1, 1);

        // Abort while waiting in FETCH: nothing consumed
        snap(); stall_cnt = 10;
        wr_q.push_back(20'h11111); wr_q.push_back(20'h22222);
        send_cmd(2'd0, 7'd0, 7'd2, 1'b0);
        @(negedge clk);
        abort = 1'b1;
        #4 check("t6_abort_gates_wr_ready", wr_ready, 0);
        @(negedge clk);
        abort = 1'b0;
        wait_end(50);
        stall_cnt = 0;
        wr_q.delete();
        check_job("t6_abort_fetch", 0, 1, 0, 0);

        // Reset in the middle of an access
        snap(); rdy_lat = -1;
        wr_q.push_back(20'h33333); expect_wr(4'b0010, 7'd30, 20'h33333);
        send_cmd(2'd1, 7'd30, 7'd1, 1'b0);
        wait_mtrans(20);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #4;
        check("t7_rst_cmd_ready", cmd_ready, 1);
        check("t7_rst_ctl", {wr_ready, busy, done, err, bus.MTRANS, bus.MWRITE}, 6'b0);
        check("t7_rst_bus", {bus.MSELx, bus.MADDR, bus.MWDATA}, 31'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_job("t7_reset", 0, 0, 1, 1);

        // Recovery, single word at the top address
        snap(); rdy_lat = 2;
        wr_q.push_back(20'hFFFFF); expect_wr(4'b0001, 7'd127, 20'hFFFFF);
        send_cmd(2'd0, 7'd127, 7'd1, 1'b0);
        wait_end(50);
        check_job("t8_top_addr", 1, 0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
